// File: rtl/line_delay_ctrl_if.sv
// Video timing in / line-delay sequencing out, shared by the timing source and the sequencer.
// Signal names keep the _i/_o direction as seen from the sequencer.
interface line_delay_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int ROW_W  = 11
);
    logic              de_i;
    logic              vs_i;
    logic [ADDR_W-1:0] addr_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] col_o;
    logic [ROW_W-1:0]  row_o;
    logic              win_valid_o;
    logic              sof_o;
    logic [ADDR_W-1:0] line_len_o;
    logic              len_err_o;
    logic              ovf_o;

    modport master (
        output de_i, vs_i,
        input  addr_o, ram_we_o, col_o, row_o, win_valid_o, sof_o, line_len_o, len_err_o, ovf_o
    );

    modport slave (
        input  de_i, vs_i,
        output addr_o, ram_we_o, col_o, row_o, win_valid_o, sof_o, line_len_o, len_err_o, ovf_o
    );
endinterface

// File: rtl/line_delay_ctrl.sv
// Address/write-enable sequencer for the BRAM line-delay chain behind the KSIZE x KSIZE window.
// Follows de/vs timing and reports window position, window-valid and line-length consistency.
module line_delay_ctrl #(
    parameter int ADDR_W = 12,
    parameter int KSIZE  = 5,
    parameter int ROW_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    line_delay_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE, HBLANK} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ROW_W-1:0]  ROW_MAX   = '1;
    localparam logic [ADDR_W-1:0] COL_THR   = ADDR_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_THR   = ROW_W'(KSIZE - 1);

    state_t            state_q;
    logic              de_q, vs_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_cnt_q, len_cnt_d;
    logic [ADDR_W-1:0] line_len_q;
    logic [ROW_W-1:0]  row_q;
    logic              first_line_q;
    logic              we_q, win_valid_q, sof_q, len_err_q, ovf_q;

    logic de_rise, vs_rise, line_start, line_end, pixel;

    // vs has priority over everything, so a coincident de rise is dropped.
    always_comb begin
        de_rise    = bus.de_i & ~de_q;
        vs_rise    = bus.vs_i & ~vs_q;
        line_start = !vs_rise && de_rise && (state_q == VBLANK || state_q == HBLANK);
        line_end   = !vs_rise && (state_q == ACTIVE) && !bus.de_i;
        pixel      = line_start || (!vs_rise && (state_q == ACTIVE) && bus.de_i);
        if (line_start) begin
            addr_d    = '0;
            len_cnt_d = ADDR_W'(1);
        end else begin
            addr_d    = (addr_q == ADDR_MAX) ? addr_q : addr_q + ADDR_W'(1);
            len_cnt_d = len_cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_VS;
            de_q         <= 1'b0;
            vs_q         <= 1'b1;
            addr_q       <= '0;
            len_cnt_q    <= '0;
            line_len_q   <= '0;
            row_q        <= '0;
            first_line_q <= 1'b0;
            we_q         <= 1'b0;
            win_valid_q  <= 1'b0;
            sof_q        <= 1'b0;
            len_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            de_q        <= bus.de_i;
            vs_q        <= bus.vs_i;
            we_q        <= pixel;
            sof_q       <= 1'b0;
            len_err_q   <= 1'b0;
            win_valid_q <= 1'b0;

            if (vs_rise) begin
                state_q      <= VBLANK;
                row_q        <= '0;
                first_line_q <= 1'b1;
                ovf_q        <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_VS: ;
                    VBLANK: if (line_start) begin
                        state_q <= ACTIVE;
                        sof_q   <= 1'b1;
                    end
                    HBLANK: if (line_start) state_q <= ACTIVE;
                    ACTIVE: if (line_end) begin
                        state_q      <= HBLANK;
                        line_len_q   <= len_cnt_q;
                        len_err_q    <= !first_line_q && (len_cnt_q != line_len_q);
                        first_line_q <= 1'b0;
                        row_q        <= (row_q == ROW_MAX) ? row_q : row_q + ROW_W'(1);
                    end
                    default: state_q <= WAIT_VS;
                endcase
            end

            // Blanking leaves addr_q untouched so the RAM contents stay put.
            if (pixel) begin
                addr_q      <= addr_d;
                len_cnt_q   <= len_cnt_d;
                win_valid_q <= (row_q >= ROW_THR) && (addr_d >= COL_THR);
                if (!line_start && addr_q == ADDR_MAX) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.addr_o      = addr_q;
    assign bus.col_o       = addr_q;
    assign bus.row_o       = row_q;
    assign bus.ram_we_o    = we_q;
    assign bus.win_valid_o = win_valid_q;
    assign bus.sof_o       = sof_q;
    assign bus.line_len_o  = line_len_q;
    assign bus.len_err_o   = len_err_q;
    assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_line_delay_ctrl.sv
// Drives two sequencers (12-bit and 3-bit address) with the same video timing and
// checks every output each cycle against an event-level frame/line model.
module tb_line_delay_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic de  = 1'b0;
    logic vs  = 1'b0;

    always #5 clk = ~clk;

    line_delay_ctrl_if #(.ADDR_W(12), .ROW_W(11)) if_a ();
    line_delay_ctrl_if #(.ADDR_W(3),  .ROW_W(11)) if_b ();

    assign if_a.de_i = de;
    assign if_a.vs_i = vs;
    assign if_b.de_i = de;
    assign if_b.vs_i = vs;

    line_delay_ctrl #(.ADDR_W(12), .KSIZE(5), .ROW_W(11)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    line_delay_ctrl #(.ADDR_W(3),  .KSIZE(5), .ROW_W(11)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: frame armed by vs, line in progress, pixel index within the line.
    int aw[2] = '{12, 3};
    int m_addr[2], m_we[2], m_row[2], m_wv[2], m_sof[2], m_len[2], m_lerr[2], m_ovf[2];
    int m_n[2];
    bit m_armed[2], m_inl[2], m_first[2], m_pend[2];
    bit pde = 1'b0, pvs = 1'b0;

    // Directed event counters on instance A (and B for overflow).
    int cnt_wv, cnt_sof, cnt_lerr, cnt_we;

    task automatic model_step(input int i);
        int amax;
        int cnt;
        amax = (1 << aw[i]) - 1;
        m_we[i] = 0; m_sof[i] = 0; m_lerr[i] = 0; m_wv[i] = 0;
        if (rst) begin
            m_addr[i] = 0; m_row[i] = 0; m_len[i] = 0; m_ovf[i] = 0;
            m_armed[i] = 0; m_inl[i] = 0; m_first[i] = 0; m_pend[i] = 0;
        end else if (vs && !pvs) begin
            m_armed[i] = 1; m_inl[i] = 0; m_row[i] = 0; m_first[i] = 1;
            m_ovf[i] = 0; m_pend[i] = 1;
        end else if (m_armed[i]) begin
            if (m_inl[i]) begin
                if (de) begin
                    m_n[i]++;
                    if (m_n[i] > amax) m_ovf[i] = 1;
                    m_we[i] = 1;
                    m_addr[i] = (m_n[i] > amax) ? amax : m_n[i];
                    m_wv[i] = (m_row[i] >= 4 && m_addr[i] >= 4) ? 1 : 0;
                end else begin
                    m_inl[i] = 0;
                    cnt = (m_n[i] + 1) % (amax + 1);
                    if (!m_first[i] && cnt != m_len[i]) m_lerr[i] = 1;
                    m_len[i] = cnt;
                    m_first[i] = 0;
                    m_row[i] = (m_row[i] < 2047) ? m_row[i] + 1 : 2047;
                end
            end else if (de && !pde) begin
                m_inl[i] = 1; m_n[i] = 0;
                m_we[i] = 1; m_addr[i] = 0;
                m_wv[i] = 0;
                m_sof[i] = m_pend[i]; m_pend[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("a.addr",  32'(if_a.addr_o),      m_addr[0]);
        chk("a.we",    32'(if_a.ram_we_o),    m_we[0]);
        chk("a.col",   32'(if_a.col_o),       m_addr[0]);
        chk("a.row",   32'(if_a.row_o),       m_row[0]);
        chk("a.wv",    32'(if_a.win_valid_o), m_wv[0]);
        chk("a.sof",   32'(if_a.sof_o),       m_sof[0]);
        chk("a.len",   32'(if_a.line_len_o),  m_len[0]);
        chk("a.lerr",  32'(if_a.len_err_o),   m_lerr[0]);
        chk("a.ovf",   32'(if_a.ovf_o),       m_ovf[0]);
        chk("b.addr",  32'(if_b.addr_o),      m_addr[1]);
        chk("b.we",    32'(if_b.ram_we_o),    m_we[1]);
        chk("b.col",   32'(if_b.col_o),       m_addr[1]);
        chk("b.row",   32'(if_b.row_o),       m_row[1]);
        chk("b.wv",    32'(if_b.win_valid_o), m_wv[1]);
        chk("b.sof",   32'(if_b.sof_o),       m_sof[1]);
        chk("b.len",   32'(if_b.line_len_o),  m_len[1]);
        chk("b.lerr",  32'(if_b.len_err_o),   m_lerr[1]);
        chk("b.ovf",   32'(if_b.ovf_o),       m_ovf[1]);
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        pde = de;
        pvs = vs;
        #1;
        chk_all();
        cnt_wv   += int'(if_a.win_valid_o);
        cnt_sof  += int'(if_a.sof_o);
        cnt_lerr += int'(if_a.len_err_o);
        cnt_we   += int'(if_a.ram_we_o);
    endtask

    task automatic drive(input logic d, input logic v, input int n);
        de = d; vs = v;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 3);
    endtask

    task automatic line(input int len, input int gap);
        drive(1'b1, 1'b0, len);
        drive(1'b0, 1'b0, gap);
    endtask

    task automatic clr_cnt();
        cnt_wv = 0; cnt_sof = 0; cnt_lerr = 0; cnt_we = 0;
    endtask

    initial begin
        clr_cnt();
        drive(1'b0, 1'b0, 3);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2);

        // Reset in the middle of an active line.
        vs_pulse();
        drive(1'b1, 1'b0, 4);
        rst = 1'b1;
        drive(1'b1, 1'b0, 3);
        chk("t1_rst_we",   32'(if_a.ram_we_o), 0);
        chk("t1_rst_addr", 32'(if_a.addr_o),   0);
        rst = 1'b0;
        clr_cnt();
        drive(1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 3);
        line(8, 4);
        line(8, 4);
        chk("t1_we_blocked", 32'(cnt_we), 0);

        // 4 lines x 8 pixels.
        vs_pulse();
        clr_cnt();
        for (int l = 0; l < 4; l++) line(8, 4);
        chk("t2_sof_count",  32'(cnt_sof),  1);
        chk("t2_lerr_count", 32'(cnt_lerr), 0);
        chk("t2_line_len",   32'(if_a.line_len_o), 8);
        chk("t2_we_count",   32'(cnt_we), 32);

        // 6 rows x 8 pixels: window valid at rows 4..5, cols 4..7.
        vs_pulse();
        clr_cnt();
        for (int l = 0; l < 6; l++) line(8, 4);
        chk("t3_wv_count", 32'(cnt_wv), 8);

        // Line lengths 8, 8, 7 then a new frame starting at 10.
        vs_pulse();
        clr_cnt();
        line(8, 4);
        line(8, 4);
        drive(1'b1, 1'b0, 7);
        drive(1'b0, 1'b0, 1);
        chk("t4_lerr_pulse", 32'(if_a.len_err_o),  1);
        chk("t4_len7",       32'(if_a.line_len_o), 7);
        drive(1'b0, 1'b0, 3);
        chk("t4_lerr_count", 32'(cnt_lerr), 1);
        vs_pulse();
        clr_cnt();
        line(10, 4);
        chk("t4_next_frame_lerr", 32'(cnt_lerr), 0);

        // Overflow on the 3-bit address instance from the previous 10-pixel line.
        chk("t5_ovf_set",  32'(if_b.ovf_o),      1);
        chk("t5_len_mod",  32'(if_b.line_len_o), 2);
        chk("t5_addr_sat", 32'(if_b.addr_o),     7);
        drive(1'b0, 1'b1, 1);
        chk("t5_ovf_clr",  32'(if_b.ovf_o),      0);
        drive(1'b0, 1'b0, 3);

        // vs and de rising together, then vs mid-line.
        line(8, 4);
        line(8, 4);
        clr_cnt();
        drive(1'b1, 1'b1, 2);
        drive(1'b1, 1'b0, 6);
        chk("t6_coincident_we", 32'(cnt_we), 0);
        chk("t6_row_zero",      32'(if_a.row_o), 0);
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 1);
        chk("t6_first_we",  32'(if_a.ram_we_o), 1);
        chk("t6_first_sof", 32'(if_a.sof_o),    1);
        drive(1'b1, 1'b0, 7);
        drive(1'b0, 1'b0, 4);
        line(5, 4);
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 3);
        chk("t6_abort_len", 32'(if_a.line_len_o), 5);
        chk("t6_abort_row", 32'(if_a.row_o),      0);

        // Randomized frames with occasional aborted lines.
        for (int f = 0; f < 12; f++) begin
            int nl;
            vs_pulse();
            nl = int'($urandom_range(2, 8));
            for (int l = 0; l < nl; l++) begin
                int len;
                len = int'($urandom_range(1, 14));
                if ($urandom_range(0, 9) == 0) begin
                    drive(1'b1, 1'b0, len);
                    drive(1'b1, 1'b1, 2);
                    drive(1'b0, 1'b0, 2);
                end else begin
                    line(len, int'($urandom_range(1, 5)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
